// File: rtl/sqrt_arb_if.sv
// Bus bundle that links the requesters, the round-robin arbiter and the sqrt engine.
interface sqrt_arb_if #(
    parameter int NREQ = 4
);
    logic                 en;
    logic [NREQ-1:0]      req_vld;
    logic [32*NREQ-1:0]   req_x;
    logic [NREQ-1:0]      req_rdy;
    logic                 eng_vld_in;
    logic [31:0]          eng_x;
    logic                 eng_vld_out;
    logic [15:0]          eng_y;
    logic [NREQ-1:0]      rsp_vld;
    logic [15:0]          rsp_y;
    logic [4:0]           outstanding;
    logic                 idle;
    logic                 err_unexp;

    // Requester/engine side: drives operands and engine results, observes the arbiter.
    modport master (
        output en, req_vld, req_x, eng_vld_out, eng_y,
        input  req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_y, outstanding, idle, err_unexp
    );

    // Arbiter side.
    modport slave (
        input  en, req_vld, req_x, eng_vld_out, eng_y,
        output req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_y, outstanding, idle, err_unexp
    );
endinterface

// File: rtl/sqrt_arb.sv
// Round-robin arbiter sharing one in-order sqrt engine among NREQ requesters.
// A tag FIFO remembers who issued each operation so results can be routed back,
// and a credit counter bounds the number of operations in flight.
module sqrt_arb #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 8,
    parameter int IDW     = 2
) (
    input logic       clk,
    input logic       rst_n,
    sqrt_arb_if.slave bus
);
    localparam int         PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [4:0] MAX_CNT = 5'(MAX_OUT);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IDW-1:0]  r_rrPtr;
    logic [4:0]      r_outstanding;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [IDW-1:0]  r_tagMem [MAX_OUT];
    logic            r_engVld;
    logic [31:0]     r_engX;
    logic [NREQ-1:0] r_rspVld;
    logic [15:0]     r_rspY;
    logic            r_errUnexp;

    logic            w_credit;
    logic            w_found;
    logic [IDW-1:0]  w_gntIdx;
    logic [NREQ-1:0] w_reqRdy;
    logic            w_xfer;
    logic [31:0]     w_operand;
    logic [IDW-1:0]  w_nextPtr;
    logic            w_fifoEmpty;
    logic            w_pop;
    logic            w_unexp;
    logic [IDW-1:0]  w_headTag;

    // Pointer advance with wrap at the configured FIFO depth.
    function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at r_rrPtr; first valid requester wins.
    always_comb begin
        logic [IDW:0] cand;
        w_found  = 1'b0;
        w_gntIdx = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, r_rrPtr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!w_found && bus.req_vld[cand[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gntIdx = cand[IDW-1:0];
            end
        end
    end

    // Select the winning operand from the packed operand bus.
    always_comb begin
        w_operand = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gntIdx == IDW'(k)) begin
                w_operand = bus.req_x[32*k +: 32];
            end
        end
    end

    // Grants need enable, a free credit and a live reset; the tag FIFO shares the credit count.
    assign w_credit    = bus.en && (r_outstanding < MAX_CNT);
    assign w_reqRdy    = (rst_n && w_credit && w_found) ? (ONE << w_gntIdx) : '0;
    assign w_xfer      = |(w_reqRdy & bus.req_vld);
    assign w_nextPtr   = (w_gntIdx == IDW'(NREQ - 1)) ? '0 : w_gntIdx + 1'b1;
    assign w_fifoEmpty = (r_outstanding == 5'd0);
    assign w_pop       = bus.eng_vld_out && !w_fifoEmpty;
    assign w_unexp     = bus.eng_vld_out && w_fifoEmpty;
    assign w_headTag   = r_tagMem[r_rdPtr];

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr <= '0;
        end else if (w_xfer) begin
            r_rrPtr <= w_nextPtr;
        end
    end

    // Tag storage; contents need no reset because occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_tagMem[r_wrPtr] <= w_gntIdx;
        end
    end

    // Tag FIFO pointers: push on every transfer, pop on every expected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_xfer) begin
                r_wrPtr <= bumpPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= bumpPtr(r_rdPtr);
            end
        end
    end

    // Credit counter: in-flight operations, equal to tag FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 5'd0;
        end else begin
            case ({w_xfer, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 5'd1;
                2'b01:   r_outstanding <= r_outstanding - 5'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Registered issue: one strobe per transfer, operand held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_engVld <= 1'b0;
            r_engX   <= '0;
        end else begin
            r_engVld <= w_xfer;
            if (w_xfer) begin
                r_engX <= w_operand;
            end
        end
    end

    // Route each expected result to the requester whose tag is at the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspVld <= '0;
            r_rspY   <= '0;
        end else begin
            r_rspVld <= w_pop ? (ONE << w_headTag) : '0;
            if (w_pop) begin
                r_rspY <= bus.eng_y;
            end
        end
    end

    // Sticky flag for results that arrive with no tag waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errUnexp <= 1'b0;
        end else if (w_unexp) begin
            r_errUnexp <= 1'b1;
        end
    end

    assign bus.req_rdy     = w_reqRdy;
    assign bus.eng_vld_in  = r_engVld;
    assign bus.eng_x       = r_engX;
    assign bus.rsp_vld     = r_rspVld;
    assign bus.rsp_y       = r_rspY;
    assign bus.outstanding = r_outstanding;
    assign bus.idle        = (r_outstanding == 5'd0) && (r_rspVld == '0);
    assign bus.err_unexp   = r_errUnexp;

endmodule

// File: tb/tb_sqrt_arb.sv
// Directed bench for sqrt_arb with a small in-order sqrt engine model.
module tb_sqrt_arb;
    localparam int NREQ    = 4;
    localparam int MAX_OUT = 8;
    localparam int IDW     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sqrt_arb_if #(.NREQ(NREQ)) bus();

    sqrt_arb #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [15:0] y; int due; } eng_t;
    typedef struct { logic [NREQ-1:0] vld; logic [15:0] y; } rsp_t;

    eng_t engQ[$];
    rsp_t rspLog[$];
    int   gntLog[$];
    int   cyc;
    int   engLat;
    bit   engStall;
    int   engCredits;
    bit   spurious;
    int   checks;
    int   errors;

    // Engine model arithmetic: integer square root of small operands.
    function automatic logic [15:0] isqrt(input logic [31:0] x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return 16'(r);
    endfunction

    // One clock: log transfers and responses, then play the engine for this cycle.
    task automatic tick();
        logic [NREQ-1:0] xfer;
        #1;
        xfer = bus.req_vld & bus.req_rdy;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (xfer[i]) gntLog.push_back(i);
        if (bus.rsp_vld != '0) rspLog.push_back('{vld: bus.rsp_vld, y: bus.rsp_y});
        if (bus.eng_vld_in) engQ.push_back('{y: isqrt(bus.eng_x), due: cyc + engLat});
        bus.eng_vld_out = 1'b0;
        if (spurious) begin
            bus.eng_vld_out = 1'b1;
            bus.eng_y       = 16'hBEEF;
            spurious        = 1'b0;
        end else if (engQ.size() > 0 && engQ[0].due <= cyc && (!engStall || engCredits > 0)) begin
            bus.eng_vld_out = 1'b1;
            bus.eng_y       = engQ[0].y;
            void'(engQ.pop_front());
            if (engStall) engCredits--;
        end
    endtask

    // Reset pulse that also resets the engine model.
    task automatic doReset();
        rst_n           = 1'b0;
        bus.en          = 1'b1;
        bus.req_vld     = '0;
        bus.req_x       = '0;
        bus.eng_vld_out = 1'b0;
        bus.eng_y       = '0;
        engQ.delete();
        rspLog.delete();
        gntLog.delete();
        engLat     = 0;
        engStall   = 1'b0;
        engCredits = 0;
        spurious   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.en          = 1'b1;
        bus.req_vld     = 4'b1111;
        bus.req_x       = '0;
        bus.eng_vld_out = 1'b0;
        bus.eng_y       = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_rdy !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_rdy: got %b expected 0000", bus.req_rdy);
        end
        checks++;
        if ({bus.eng_vld_in, bus.eng_x} !== 33'd0) begin
            errors++; $display("[TB] FAIL reset_issue: got vld=%b x=%0d expected 0/0", bus.eng_vld_in, bus.eng_x);
        end
        checks++;
        if ({bus.rsp_vld, bus.rsp_y} !== 20'd0) begin
            errors++; $display("[TB] FAIL reset_rsp: got vld=%b y=%0d expected 0/0", bus.rsp_vld, bus.rsp_y);
        end
        checks++;
        if ({bus.outstanding, bus.idle, bus.err_unexp} !== {5'd0, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL reset_status: got out=%0d idle=%b err=%b expected 0/1/0",
                               bus.outstanding, bus.idle, bus.err_unexp);
        end
        doReset();
    endtask

    task automatic test_single();
        int c0;
        doReset();
        engLat = 10;
        bus.req_x[95:64] = 32'd144;
        bus.req_vld      = 4'b0100;
        #1;
        checks++;
        if (bus.req_rdy !== 4'b0100) begin
            errors++; $display("[TB] FAIL single_rdy: got %b expected 0100", bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        c0 = cyc;
        checks++;
        if ({bus.eng_vld_in, bus.eng_x} !== {1'b1, 32'd144}) begin
            errors++; $display("[TB] FAIL single_issue: got vld=%b x=%0d expected 1/144", bus.eng_vld_in, bus.eng_x);
        end
        checks++;
        if ({bus.outstanding, bus.idle} !== {5'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL single_busy: got out=%0d idle=%b expected 1/0", bus.outstanding, bus.idle);
        end
        tick();
        checks++;
        if (bus.eng_vld_in !== 1'b0) begin
            errors++; $display("[TB] FAIL single_one_strobe: got %b expected 0", bus.eng_vld_in);
        end
        for (int n = 0; n < 30 && rspLog.size() == 0; n++) tick();
        checks++;
        if (rspLog.size() != 1 || rspLog[0].vld !== 4'b0100 || rspLog[0].y !== 16'd12 || cyc != c0 + 11) begin
            errors++; $display("[TB] FAIL single_rsp: got count=%0d vld=%b y=%0d at +%0d expected 1/0100/12 at +11",
                               rspLog.size(), bus.rsp_vld, bus.rsp_y, cyc - c0);
        end
        checks++;
        if ({bus.outstanding, bus.idle} !== {5'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL single_rsp_cycle: got out=%0d idle=%b expected 0/0", bus.outstanding, bus.idle);
        end
        tick();
        checks++;
        if ({bus.rsp_vld, bus.rsp_y, bus.idle} !== {4'b0000, 16'd12, 1'b1}) begin
            errors++; $display("[TB] FAIL single_after: got vld=%b y=%0d idle=%b expected 0000/12/1",
                               bus.rsp_vld, bus.rsp_y, bus.idle);
        end
    endtask

    task automatic test_round_robin();
        int expY[4] = '{1, 2, 3, 4};
        doReset();
        engLat = 0;
        bus.req_x   = {32'd16, 32'd9, 32'd4, 32'd1};
        bus.req_vld = 4'b1111;
        repeat (8) tick();
        bus.req_vld = '0;
        for (int n = 0; n < 20 && !bus.idle; n++) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= gntLog.size() || gntLog[i] != i % 4) begin
                errors++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i,
                                   (i < gntLog.size()) ? gntLog[i] : -1, i % 4);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= rspLog.size() || rspLog[i].vld !== (4'b0001 << (i % 4)) || rspLog[i].y !== 16'(expY[i % 4])) begin
                errors++; $display("[TB] FAIL rr_rsp[%0d]: got vld=%b y=%0d expected vld=%b y=%0d", i,
                                   (i < rspLog.size()) ? rspLog[i].vld : 4'bx, (i < rspLog.size()) ? rspLog[i].y : 16'hx,
                                   4'b0001 << (i % 4), expY[i % 4]);
            end
        end
        checks++;
        if ({bus.outstanding, bus.idle} !== {5'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL rr_drain: got out=%0d idle=%b expected 0/1", bus.outstanding, bus.idle);
        end
    endtask

    task automatic test_credit_limit();
        doReset();
        engStall = 1'b1;
        bus.req_x[31:0] = 32'd25;
        bus.req_vld     = 4'b0001;
        repeat (12) tick();
        checks++;
        if (gntLog.size() != 8 || bus.outstanding !== 5'd8 || bus.req_rdy !== 4'b0000) begin
            errors++; $display("[TB] FAIL credit_full: got grants=%0d out=%0d rdy=%b expected 8/8/0000",
                               gntLog.size(), bus.outstanding, bus.req_rdy);
        end
        engCredits = 1;
        tick();
        checks++;
        if (bus.req_rdy !== 4'b0000) begin
            errors++; $display("[TB] FAIL credit_same_cycle: got rdy=%b expected 0000", bus.req_rdy);
        end
        tick();
        checks++;
        if ({bus.outstanding, bus.rsp_vld, bus.rsp_y, bus.req_rdy} !== {5'd7, 4'b0001, 16'd5, 4'b0001}) begin
            errors++; $display("[TB] FAIL credit_freed: got out=%0d rsp=%b y=%0d rdy=%b expected 7/0001/5/0001",
                               bus.outstanding, bus.rsp_vld, bus.rsp_y, bus.req_rdy);
        end
        tick();
        checks++;
        if (gntLog.size() != 9 || bus.outstanding !== 5'd8) begin
            errors++; $display("[TB] FAIL credit_regrant: got grants=%0d out=%0d expected 9/8", gntLog.size(), bus.outstanding);
        end
        bus.req_vld = '0;
        engStall    = 1'b0;
        for (int n = 0; n < 40 && !bus.idle; n++) tick();
        checks++;
        if (bus.idle !== 1'b1 || rspLog.size() != 9) begin
            errors++; $display("[TB] FAIL credit_drain: got idle=%b rsp=%0d expected 1/9", bus.idle, rspLog.size());
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        engStall = 1'b1;
        bus.req_x[63:32] = 32'd49;
        bus.req_vld      = 4'b0010;
        repeat (3) tick();
        bus.req_vld = '0;
        bus.req_x[127:96] = 32'd81;
        engCredits = 1;
        tick();
        bus.req_vld = 4'b1000;
        #1;
        checks++;
        if (bus.outstanding !== 5'd3 || bus.req_rdy !== 4'b1000) begin
            errors++; $display("[TB] FAIL simul_setup: got out=%0d rdy=%b expected 3/1000", bus.outstanding, bus.req_rdy);
        end
        tick();
        bus.req_vld = '0;
        checks++;
        if ({bus.outstanding, bus.rsp_vld, bus.rsp_y} !== {5'd3, 4'b0010, 16'd7}) begin
            errors++; $display("[TB] FAIL simul_net_zero: got out=%0d rsp=%b y=%0d expected 3/0010/7",
                               bus.outstanding, bus.rsp_vld, bus.rsp_y);
        end
        engStall = 1'b0;
        for (int n = 0; n < 40 && !bus.idle; n++) tick();
        checks++;
        if (rspLog.size() != 4 || rspLog[1].vld !== 4'b0010 || rspLog[2].vld !== 4'b0010 ||
            rspLog[3].vld !== 4'b1000 || rspLog[3].y !== 16'd9) begin
            errors++; $display("[TB] FAIL simul_tags: got count=%0d last vld=%b y=%0d expected 4/1000/9", rspLog.size(),
                               (rspLog.size() > 0) ? rspLog[rspLog.size()-1].vld : 4'bx,
                               (rspLog.size() > 0) ? rspLog[rspLog.size()-1].y : 16'hx);
        end
    endtask

    task automatic test_spurious();
        doReset();
        checks++;
        if (bus.idle !== 1'b1) begin
            errors++; $display("[TB] FAIL spur_idle: got %b expected 1", bus.idle);
        end
        spurious = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.err_unexp, bus.rsp_vld, bus.outstanding} !== {1'b1, 4'b0000, 5'd0}) begin
            errors++; $display("[TB] FAIL spur_flag: got err=%b rsp=%b out=%0d expected 1/0000/0",
                               bus.err_unexp, bus.rsp_vld, bus.outstanding);
        end
        repeat (3) tick();
        checks++;
        if (bus.err_unexp !== 1'b1 || bus.rsp_y !== 16'd0 || rspLog.size() != 0) begin
            errors++; $display("[TB] FAIL spur_sticky: got err=%b y=%0d rsp=%0d expected 1/0/0",
                               bus.err_unexp, bus.rsp_y, rspLog.size());
        end
        doReset();
        checks++;
        if (bus.err_unexp !== 1'b0) begin
            errors++; $display("[TB] FAIL spur_clear: got %b expected 0", bus.err_unexp);
        end
    endtask

    task automatic test_drain_and_reset();
        logic [3:0]  expV[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] expY[5] = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd10};
        doReset();
        engStall    = 1'b1;
        bus.req_x   = {32'd169, 32'd144, 32'd121, 32'd100};
        bus.req_vld = 4'b1111;
        repeat (5) tick();
        bus.en = 1'b0;
        #1;
        checks++;
        if (gntLog.size() != 5 || bus.outstanding !== 5'd5 || bus.req_rdy !== 4'b0000) begin
            errors++; $display("[TB] FAIL drain_block: got grants=%0d out=%0d rdy=%b expected 5/5/0000",
                               gntLog.size(), bus.outstanding, bus.req_rdy);
        end
        engStall = 1'b0;
        for (int n = 0; n < 40 && rspLog.size() < 5; n++) tick();
        checks++;
        if (rspLog.size() != 5 || bus.idle !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_last: got rsp=%0d idle=%b expected 5/0", rspLog.size(), bus.idle);
        end
        for (int i = 0; i < 5 && i < rspLog.size(); i++) begin
            checks++;
            if (rspLog[i].vld !== expV[i] || rspLog[i].y !== expY[i]) begin
                errors++; $display("[TB] FAIL drain_rsp[%0d]: got vld=%b y=%0d expected vld=%b y=%0d",
                                   i, rspLog[i].vld, rspLog[i].y, expV[i], expY[i]);
            end
        end
        tick();
        checks++;
        if (bus.idle !== 1'b1 || gntLog.size() != 5) begin
            errors++; $display("[TB] FAIL drain_idle: got idle=%b grants=%0d expected 1/5", bus.idle, gntLog.size());
        end
        bus.en = 1'b1;
        engLat = 2;
        repeat (6) tick();
        checks++;
        if (bus.eng_vld_in !== 1'b1 || bus.rsp_vld === 4'b0000) begin
            errors++; $display("[TB] FAIL midreset_busy: got eng_vld_in=%b rsp=%b expected 1/nonzero",
                               bus.eng_vld_in, bus.rsp_vld);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_rdy, bus.eng_vld_in, bus.eng_x, bus.rsp_vld, bus.rsp_y,
             bus.outstanding, bus.idle, bus.err_unexp} !== {4'b0000, 1'b0, 32'd0, 4'b0000, 16'd0, 5'd0, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL midreset_values: got rdy=%b iv=%b x=%0d rv=%b y=%0d out=%0d idle=%b err=%b expected all reset",
                               bus.req_rdy, bus.eng_vld_in, bus.eng_x, bus.rsp_vld, bus.rsp_y,
                               bus.outstanding, bus.idle, bus.err_unexp);
        end
        doReset();
        repeat (3) tick();
        checks++;
        if ({bus.err_unexp, bus.idle} !== {1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL midreset_after: got err=%b idle=%b expected 0/1", bus.err_unexp, bus.idle);
        end
    endtask

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run the scenarios in order, then report.
    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_credit_limit();
        test_simultaneous();
        test_spurious();
        test_drain_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_arb.md
SQRT_ARB -- requirements
Module: sqrt_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter MAX_OUT, default 8: maximum outstanding engine operations; legal range 1..16 (engine input FIFO depth is 16).
REQ-003 Parameter IDW, default 2: requester-index width, equal to clog2(NREQ).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port en, input, 1 bit: grant enable; 0 blocks new grants while in-flight operations drain.
REQ-007 Port req_vld, input, NREQ bits: per-requester operand valid.
REQ-008 Port req_x, input, 32*NREQ bits: operands; requester i occupies bits [32i+31:32i].
REQ-009 Port req_rdy, output, NREQ bits: per-requester accept; one-hot or zero.
REQ-010 Port eng_vld_in, output, 1 bit: issue strobe to the sqrt engine.
REQ-011 Port eng_x, output, 32 bits: operand to the engine.
REQ-012 Port eng_vld_out, input, 1 bit: engine result strobe; results return in issue order and cannot be stalled.
REQ-013 Port eng_y, input, 16 bits: engine result.
REQ-014 Port rsp_vld, output, NREQ bits: per-requester result valid; one-hot or zero; no backpressure.
REQ-015 Port rsp_y, output, 16 bits: result bus shared by all requesters.
REQ-016 Port outstanding, output, 5 bits: current in-flight count.
REQ-017 Port idle, output, 1 bit: high when outstanding is 0 and no response is pending.
REQ-018 Port err_unexp, output, 1 bit: sticky flag, set when eng_vld_out arrives with no tag queued.

Function
REQ-019 Grant condition: en=1, outstanding<MAX_OUT, and at least one req_vld bit set; otherwise req_rdy is all zero.
REQ-020 Arbitration is round-robin, combinational from registered pointer rr_ptr. Search order: rr_ptr, rr_ptr+1, ... modulo NREQ; the first valid requester wins.
REQ-021 On a grant to requester g, rr_ptr becomes (g+1) mod NREQ the next cycle. rr_ptr holds when there is no grant.
REQ-022 Handshake: a transfer occurs when req_vld[g] and req_rdy[g] are both high. The requester holds req_vld and req_x stable until the transfer. req_rdy may depend combinationally on req_vld.
REQ-023 Issue is registered: the cycle after a transfer, eng_vld_in=1 for exactly one cycle and eng_x holds the granted operand. Back-to-back grants give one issue per cycle.
REQ-024 Tag FIFO: MAX_OUT entries, IDW bits wide. Push g on each transfer. Pop on each eng_vld_out.
REQ-025 Credit counter outstanding: +1 on transfer, -1 on eng_vld_out with tag FIFO non-empty, net 0 when both happen in the same cycle. A completion frees its credit for grant evaluation starting the next cycle.
REQ-026 Response: the cycle after eng_vld_out, rsp_vld[t]=1 for one cycle and rsp_y=eng_y, where t is the popped tag. rsp_y holds its last value otherwise.
REQ-027 Unexpected result: eng_vld_out with the tag FIFO empty sets err_unexp, does not drive rsp_vld, and leaves outstanding unchanged. err_unexp clears only on reset.
REQ-028 en=0 while busy: no new grants; in-flight results are still routed; idle asserts after the last response cycle.
REQ-029 outstanding never exceeds MAX_OUT; the tag FIFO can never overflow.
REQ-030 The block performs no arithmetic on operands or results; it passes them unmodified.

Reset
REQ-031 On rst_n low, immediately: eng_vld_in=0, eng_x=0, rsp_vld=0, rsp_y=0, outstanding=0, idle=1, err_unexp=0, rr_ptr=0, tag FIFO empty, req_rdy=0.
REQ-032 Reset mid-operation discards all tags. Results the engine delivers after reset are unexpected and set err_unexp, unless the engine is reset together with this block, which is the required system integration.

Verification
REQ-033 Single request: req_vld=4'b0100, x=144; engine model returns 12 after 10 cycles -> eng_x=144 one cycle after the transfer; rsp_vld=4'b0100 with rsp_y=12 one cycle after eng_vld_out; outstanding returns to 0; idle=1.
REQ-034 All four requesters held valid with x=1,4,9,16 and a zero-latency engine model -> grant order 0,1,2,3,0...; responses 1,2,3,4 routed to requesters 0..3 in order.
REQ-035 Credit limit: MAX_OUT=8, engine stalled, requester 0 continuously valid -> exactly 8 transfers, then req_rdy=0 and outstanding=8; one eng_vld_out -> a grant is allowed the following cycle.
REQ-036 Simultaneous grant and completion with outstanding=3 -> outstanding stays 3; tag pushed and tag popped correctly.
REQ-037 Spurious eng_vld_out with idle=1 -> err_unexp=1, rsp_vld stays 0; err_unexp persists until rst_n pulse.
REQ-038 en dropped with 5 outstanding -> no further req_rdy; all 5 responses delivered; idle=1 after the last; rst_n asserted mid-stream -> all outputs at REQ-031 values in the same cycle.
